// File: rtl/microseq_controller.sv
// microseq_controller: microcode sequencer producing the 16-bit datapath control word per T-state.
// Define ILLEGAL_TRAP_EN to halt on undefined opcodes and flag them on the `illegal` output.
module microseq_controller #(
  parameter int OPW    = 4,
  parameter int STEPW  = 3,
  parameter int NSTEPS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [OPW-1:0]   instruction,
  input  logic             carry,
  input  logic             zero,
  output logic [15:0]      ctrlwrd,
  output logic [STEPW-1:0] step,
  output logic             last,
`ifdef ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic             halted
);
  localparam logic [15:0] J   = 16'h0001, CO = 16'h0002, CE = 16'h0004, OI = 16'h0008;
  localparam logic [15:0] BI  = 16'h0010, SU = 16'h0020, SO = 16'h0040, AO = 16'h0080;
  localparam logic [15:0] AI  = 16'h0100, II = 16'h0200, IO = 16'h0400, RO = 16'h0800;
  localparam logic [15:0] RI  = 16'h1000, MI = 16'h2000, HLT = 16'h4000, FI = 16'h8000;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4, OP_OUT = 4'h5, OP_JMP = 4'h6, OP_LDI = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8, OP_JZ  = 4'hB, OP_HLT = 4'hF;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic [STEPW-1:0] step_q, step_d;
  logic             halted_q, halted_d;
  logic             in_range, defined, undef, advance, fin, stop, trap;
  logic [3:0]       op;
  logic [15:0]      word;
  assign in_range = 32'(instruction) < 32'd16;
  assign defined  = in_range && (instruction[3:0] inside
                    {OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_OUT, OP_JMP, OP_LDI, OP_JC, OP_JZ, OP_HLT});
  assign undef    = !defined;
  // Undefined opcodes decode as NOP unless the trap turns them into a halt at T2.
  assign op       = defined ? instruction[3:0] : OP_NOP;
  always_comb begin
    word = '0;
    fin  = 1'b1;
    stop = 1'b0;
    trap = 1'b0;
    if (step_q == STEPW'(0)) begin
      word = MI | CO;
      fin  = 1'b0;
    end else if (step_q == STEPW'(1)) begin
      word = RO | II | CE;
      fin  = op == OP_NOP && !(TRAP && undef);
    end else if (step_q == STEPW'(2)) begin
      if (TRAP && undef) begin
        word = HLT;
        stop = 1'b1;
        trap = 1'b1;
      end else begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            word = MI | IO;
            fin  = 1'b0;
          end
          OP_OUT:  word = AO | OI;
          OP_JMP:  word = IO | J;
          OP_LDI:  word = IO | AI;
          OP_JC:   word = carry ? IO | J : '0;
          OP_JZ:   word = zero ? IO | J : '0;
          OP_HLT: begin
            word = HLT;
            stop = 1'b1;
          end
          default: word = '0;
        endcase
      end
    end else if (step_q == STEPW'(3)) begin
      case (op)
        OP_LDA:         word = RO | AI;
        OP_STA:         word = AO | RI;
        OP_ADD, OP_SUB: begin
          word = RO | BI;
          fin  = 1'b0;
        end
        default:        word = '0;
      endcase
    end else if (step_q == STEPW'(4)) begin
      word = op == OP_ADD ? SO | AI | FI : op == OP_SUB ? SO | SU | AI | FI : '0;
    end
  end
  assign advance = enable && !halted_q && !reset;
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (advance) begin
      step_d   = (fin || step_q == STEPW'(NSTEPS - 1)) ? '0 : step_q + 1'b1;
      halted_d = stop;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end
`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal_d = illegal_q | (advance && trap);
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  logic unused_trap;
  assign unused_trap = trap;
`endif
  assign ctrlwrd = reset ? '0 : halted_q ? HLT : enable ? word : '0;
  assign step    = step_q;
  assign last    = fin;
  assign halted  = halted_q;
endmodule

// File: doc/microseq_controller.md
Name: microseq_controller

Overview:
- Parametrised microcode sequencer for the 8-bit bus CPU; successor to the fixed 5-step controller.
- Generates the 16-bit control word for each T-state from the current step, the opcode and the ALU flags.
- Adds variable-length instructions, conditional jumps on carry/zero, a flags-latch control bit, a latched halt and a synchronous reset.
- Sits between the instruction register / flags register and the datapath, which samples `ctrlwrd` on the rising edge of `clk`.

Parameters:
- OPW, 4, opcode width. Legal range 4..8; opcodes at or above 16 are undefined.
- STEPW, 3, step counter width.
- NSTEPS, 8, maximum T-states per instruction. Requires 5 <= NSTEPS <= 2^STEPW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  step enable; low freezes the sequencer.
- instruction  input  OPW  opcode from the instruction register.
- carry  input  1  latched ALU carry flag.
- zero  input  1  latched ALU zero flag.
- ctrlwrd  output  16  control word for the current step (combinational).
- step  output  STEPW  current T-state, registered.
- last  output  1  high when the current step is the final step of the instruction.
- halted  output  1  registered halt latch.

Behaviour:
- Control bit layout:
  - J=0, CO=1, CE=2, OI=3, BI=4, SU=5, SO=6, AO=7
  - AI=8, II=9, IO=10, RO=11, RI=12, MI=13, HLT=14, FI=15
- Reset (sampled at a rising edge): step<=0, halted<=0.
- ctrlwrd = 0 whenever any of these hold: reset high, enable low, or halted.
  - Exception: while halted and not in reset, ctrlwrd = bit HLT only.
- Fetch steps, common to all opcodes:
  - T0 = MI|CO.
  - T1 = RO|II|CE.
- Execute steps by opcode (each instruction ends on the step listed as "last"):
  - NOP 0000: last = T1.
  - LDA 0001: T2 = MI|IO; T3 = RO|AI (last).
  - ADD 0010: T2 = MI|IO; T3 = RO|BI; T4 = SO|AI|FI (last).
  - SUB 0011: same as ADD, with T4 = SO|SU|AI|FI.
  - STA 0100: T2 = MI|IO; T3 = AO|RI (last).
  - OUT 0101: T2 = AO|OI (last).
  - JMP 0110: T2 = IO|J (last).
  - LDI 0111: T2 = IO|AI (last).
  - JC 1000: T2 = IO|J if carry, else 0 (last). Flags are sampled combinationally during T2.
  - JZ 1011: as JC, using zero.
  - HLT 1111: T2 = HLT (last).
- Undefined opcodes behave as NOP.
- Stepping, on a rising edge with enable=1, halted=0 and reset=0:
  - If last, step<=0.
  - Otherwise step<=step+1.
  - Watchdog: if step = NSTEPS-1, step<=0 regardless of last.
- Halt: on the edge that ends HLT T2, halted<=1 and step<=0.
  - halted is cleared only by reset.
  - enable has no effect while halted.
- Instruction-register timing: the IR loads at the edge ending T1. The opcode is first used for decode at T1's last evaluation and at T2.
  - The T1 word is opcode-independent, except for last (NOP), which uses the IR value visible during T1.
- enable low: step, halted and last hold; only ctrlwrd is forced to 0. Resuming continues from the held step.
- Reset mid-instruction: the next cycle is T0 with ctrlwrd = MI|CO, provided enable=1.
- Simultaneous reset and halt edge: reset wins, halted=0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- When defined:
  - Adds output port `illegal` (1 bit, registered, reset 0).
  - An undefined opcode at T2 drives ctrlwrd = HLT during T2.
  - At the end of that T2, both halted and illegal are set to 1.
- When undefined:
  - No `illegal` port.
  - Undefined opcodes execute as NOP (last = T1).

Test Plan:
1. Reset, then enable=1 with opcode LDA -> ctrlwrd sequence 0x2002, 0x0A04, 0x2400, 0x0900, then back to 0x2002. last is high only at T3.
2. SUB then ADD, back to back -> T4 words 0x8160 and 0x8140. Step wraps 4->0 and the next T0 = 0x2002.
3. JC with carry=0, then carry=1 -> T2 word 0x0000 then 0x0401. Both instructions end at T2.
4. Drop enable during LDA T3 for 3 cycles -> ctrlwrd=0 and step=3 held. On resume, ctrlwrd=0x0900 and the instruction completes.
5. HLT -> T2 = 0x4000; afterwards halted=1 and ctrlwrd=0x4000 for 20 cycles, regardless of enable. Pulsing reset gives step=0, halted=0, ctrlwrd=0x2002.
6. With ILLEGAL_TRAP_EN and opcode 1100 -> T2 = 0x4000; after that edge illegal=1 and halted=1. Without the macro, the same opcode ends at T1 as a NOP.
